branch_comp: RTL and testbench

BRANCH_COMP -- requirements
Module: branch_comp

---
 rtl/branch_comp_pkg.sv | 11 +
 rtl/branch_cmp_core.sv | 21 ++
 rtl/branch_comp.sv | 69 ++++++
 tb/tb_branch_comp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/branch_comp_pkg.sv
// Shared constants for the branch comparator: default operand width and RV32I branch funct3 codes.
package branch_comp_pkg;
  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/branch_cmp_core.sv
// Equality and less-than compare; the signed mode flips both MSBs and reuses the unsigned compare.
module branch_cmp_core
  import branch_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             eq,
  output logic             lt
);
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;

  assign a_m = is_unsigned ? a : {~a[WIDTH-1], a[WIDTH-2:0]};
  assign b_m = is_unsigned ? b : {~b[WIDTH-1], b[WIDTH-2:0]};

  assign eq = (a == b);
  assign lt = (a_m < b_m);
endmodule

// File: rtl/branch_comp.sv
// Branch comparator with combinational eq/lt/taken and a valid-qualified output register stage.
// Define BRANCH_COMP_TAKEN_EN to build the funct3 taken decoder; otherwise taken/taken_q are 0.
module branch_comp
  import branch_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             un,
  input  logic [2:0]       funct3,
  input  logic             valid_in,
  output logic             eq,
  output logic             lt,
  output logic             taken,
  output logic             eq_q,
  output logic             lt_q,
  output logic             taken_q,
  output logic             valid_q
);
  logic br_eq;
  logic br_lt;

  branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a(d1), .b(d2), .is_unsigned(un), .eq(eq), .lt(lt)
  );

  // Separate compare so the branch decision follows funct3[1], never the un port.
  branch_cmp_core #(.WIDTH(WIDTH)) u_br_cmp (
    .a(d1), .b(d2), .is_unsigned(funct3[1]), .eq(br_eq), .lt(br_lt)
  );

`ifdef BRANCH_COMP_TAKEN_EN
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = br_eq;
      F3_BNE:  taken = ~br_eq;
      F3_BLT:  taken = br_lt;
      F3_BGE:  taken = ~br_lt;
      F3_BLTU: taken = br_lt;
      F3_BGEU: taken = ~br_lt;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unused_br;
  assign unused_br = ^{funct3, br_eq, br_lt};
  assign taken = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      taken_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        eq_q    <= eq;
        lt_q    <= lt;
        taken_q <= taken;
      end
    end
  end
endmodule

// File: tb/tb_branch_comp.sv
// Scoreboard bench for branch_comp: stimulus pushes expected registered results, a monitor pops on valid_q.
module tb_branch_comp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        un = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        valid_in = 1'b0;
  logic        eq, lt, taken, eq_q, lt_q, taken_q, valid_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic eq;
    logic lt;
    logic taken;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic        tk;
  } vec_t;
  vec_t vecs[$];

  branch_comp #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .un(un), .funct3(funct3),
    .valid_in(valid_in), .eq(eq), .lt(lt), .taken(taken),
    .eq_q(eq_q), .lt_q(lt_q), .taken_q(taken_q), .valid_q(valid_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic tk_exp(input logic t);
`ifdef BRANCH_COMP_TAKEN_EN
    return t;
`else
    return 1'b0 & t;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (valid_q === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=valid_q required=empty_queue at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("eq_q", eq_q, e.eq);
        chk("lt_q", lt_q, e.lt);
        chk("taken_q", taken_q, e.taken);
      end
    end
  end

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    d1 = v.a; d2 = v.b; un = v.u; funct3 = v.f3; valid_in = 1'b1;
    #1;
    chk("eq", eq, v.eq);
    chk("lt", lt, v.lt);
    chk("taken", taken, tk_exp(v.tk));
    e.eq = v.eq; e.lt = v.lt; e.taken = tk_exp(v.tk);
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic u,
                              input logic [2:0] f3, input logic e, input logic l, input logic t);
    vec_t v;
    v.a = a; v.b = b; v.u = u; v.f3 = f3; v.eq = e; v.lt = l; v.tk = t;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0, 3'b000, 1, 0, 1));
    vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 3'b001, 1, 0, 0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b101, 1, 0, 1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b111, 1, 0, 1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0, 1, 1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 0, 0, 0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b111, 0, 0, 1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b010, 0, 1, 0));
    vecs.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b011, 0, 1, 0));
    vecs.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 0, 0, 1));
    vecs.push_back(mk(32'h0000_0000, 32'h8000_0000, 1'b0, 3'b110, 0, 0, 1));
    vecs.push_back(mk(32'h0000_0000, 32'h8000_0000, 1'b1, 3'b101, 0, 1, 1));
    vecs.push_back(mk(32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, 3'b001, 0, 1, 1));
    vecs.push_back(mk(32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, 3'b100, 0, 1, 1));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0002, 1'b0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0002, 1'b1, 3'b111, 0, 0, 1));
    vecs.push_back(mk(32'h0000_0002, 32'h0000_0005, 1'b0, 3'b100, 0, 1, 1));

    // Reset state before any clock edge
    #2;
    chk("rst_eq_q", eq_q, 1'b0);
    chk("rst_lt_q", lt_q, 1'b0);
    chk("rst_taken_q", taken_q, 1'b0);
    chk("rst_valid_q", valid_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Hold: valid_in low with new operands keeps the previous capture (lt_q=1 from 2<5)
    @(negedge clk);
    valid_in = 1'b0; d1 = 32'd5; d2 = 32'd2; un = 1'b0; funct3 = 3'b000;
    @(posedge clk);
    #2;
    chk("hold_lt_q", lt_q, 1'b1);
    chk("hold_eq_q", eq_q, 1'b0);
    chk("hold_taken_q", taken_q, tk_exp(1'b1));
    chk("hold_valid_q", valid_q, 1'b0);

    // Capture again, then assert reset between edges
    apply(mk(32'h0000_0002, 32'h0000_0005, 1'b0, 3'b100, 0, 1, 1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_eq_q", eq_q, 1'b0);
    chk("async_lt_q", lt_q, 1'b0);
    chk("async_taken_q", taken_q, 1'b0);
    chk("async_valid_q", valid_q, 1'b0);
    chk("rst_comb_lt", lt, 1'b1);
    chk("rst_comb_eq", eq, 1'b0);

    // First capture on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    d1 = 32'd7; d2 = 32'd7; un = 1'b1; funct3 = 3'b000; valid_in = 1'b1;
    begin
      exp_t e;
      e.eq = 1'b1; e.lt = 1'b0; e.taken = tk_exp(1'b1);
      sb.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0 pending", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
